// File: rtl/i2c_pkg.sv
// +----------------------------------------------------------------------+
// | i2c_pkg -- shared I2C target state encoding and byte width. Rev 1.0  |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none
package i2c_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_ADDR      = 3'd1;
  localparam state_t ST_ADDR_ACK  = 3'd2;
  localparam state_t ST_WRITE     = 3'd3;
  localparam state_t ST_WRITE_ACK = 3'd4;
  localparam state_t ST_READ      = 3'd5;
  localparam state_t ST_READ_ACK  = 3'd6;
  localparam state_t ST_WAIT_STOP = 3'd7;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_monitor.sv
// +----------------------------------------------------------------------+
// | i2c_bus_monitor -- SCL/SDA synchronizer, edge and START/STOP detect. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none
module i2c_bus_monitor
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic                   scl_s, sda_s;

  generate
    if (SYNC_STAGES > 1) begin : g_shift
      always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      end
    end else begin : g_single
      always_comb begin
        scl_sync_d = scl_i;
        sda_sync_d = sda_i;
      end
    end
  endgenerate

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  always_comb begin
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
  end

  // Reset to 1 so the idle bus never looks like an edge or START.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule
`default_nettype wire

// File: rtl/axis_i2c_slave.sv
// +----------------------------------------------------------------------+
// | axis_i2c_slave -- I2C target bridging bus writes/reads to AXI-Stream.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none
module axis_i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              i2c_scl_i,
  inout  wire               i2c_sda_io,
  output logic [BYTE_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  input  logic [BYTE_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic              busy_o
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_monitor #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_mon (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .scl_i      (i2c_scl_i),
    .sda_i      (i2c_sda_io),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  state_t            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] m_tdata_q, m_tdata_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic              s_tready_q, s_tready_d;
  logic              sda_low_q, sda_low_d;
  logic              busy_q, busy_d;
  logic              rw_q, rw_d;
  logic              mack_q, mack_d;
  logic              load_rd;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q & ~m_axis_tready;
    s_tready_d = 1'b0;
    sda_low_d  = sda_low_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    mack_d     = mack_q;
    load_rd    = 1'b0;

    if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_low_d = 1'b0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            if (shift_q[7:1] == SLAVE_ADDR) begin
              state_d   = ST_ADDR_ACK;
              sda_low_d = 1'b1;
              rw_d      = shift_q[0];
            end else begin
              state_d = ST_WAIT_STOP;
              busy_d  = 1'b0;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              load_rd = 1'b1;
            end else begin
              state_d   = ST_WRITE;
              sda_low_d = 1'b0;
            end
          end
        end
        ST_WRITE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            // A byte still waiting downstream forces this one to be dropped.
            if (!m_tvalid_q) begin
              state_d    = ST_WRITE_ACK;
              sda_low_d  = 1'b1;
              m_tdata_d  = shift_q;
              m_tvalid_d = 1'b1;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        ST_WRITE_ACK: begin
          if (scl_fall) begin
            state_d   = ST_WRITE;
            sda_low_d = 1'b0;
          end
        end
        ST_READ: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              state_d   = ST_READ_ACK;
              bit_cnt_d = 4'd0;
              sda_low_d = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              shift_d   = {shift_q[6:0], 1'b0};
              sda_low_d = ~shift_q[6];
            end
          end
        end
        ST_READ_ACK: begin
          if (scl_rise) begin
            mack_d = ~sda_s;
          end else if (scl_fall) begin
            if (mack_q) begin
              load_rd = 1'b1;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        default: begin
        end
      endcase
    end

    // Read byte fetch; the MSB goes onto the bus on the same falling edge.
    if (load_rd) begin
      state_d    = ST_READ;
      bit_cnt_d  = 4'd0;
      shift_d    = s_axis_tvalid ? s_axis_tdata : 8'hFF;
      s_tready_d = s_axis_tvalid;
      sda_low_d  = ~shift_d[7];
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      s_tready_q <= 1'b0;
      sda_low_q  <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      mack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      s_tready_q <= s_tready_d;
      sda_low_q  <= sda_low_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      mack_q     <= mack_d;
    end
  end

  assign i2c_sda_io    = sda_low_q ? 1'b0 : 1'bz;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign s_axis_tready = s_tready_q;
  assign busy_o        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_i2c_slave.sv
// +----------------------------------------------------------------------+
// | tb_axis_i2c_slave -- bus-master stimulus with m_axis scoreboard.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none
module tb_axis_i2c_slave;

  localparam int QT = 100;
  localparam int HT = 200;

  logic       clk;
  logic       arstn;
  logic       scl;
  logic       m_sda_low;
  wire        sda_bus;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic       busy;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  // Clock edges are offset so bus changes at multiples of 100 ns never coincide with them.
  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  axis_i2c_slave #(
    .SLAVE_ADDR  (7'h50),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i         (clk),
    .arstn_i       (arstn),
    .i2c_scl_i     (scl),
    .i2c_sda_io    (sda_bus),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .busy_o        (busy)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         deliveries = 0;
  int         s_pulses = 0;
  logic [7:0] s_src[4];
  int         s_idx = 0;
  bit         dut_drove = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: m_axis scoreboard, s_axis consumption, and DUT SDA activity.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (m_tvalid && m_tready) begin
        deliveries++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m_axis_unexpected actual=0x%0h expected=none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          check("m_axis_tdata", {24'd0, m_tdata}, {24'd0, e});
        end
      end
      if (s_tready) begin
        s_pulses++;
        s_idx++;
        s_tdata = s_src[s_idx % 4];
      end
      if (!m_sda_low && sda_bus === 1'b0) dut_drove = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic set_tready(input logic v);
    @(posedge clk);
    #2 m_tready = v;
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; #QT;
    scl = 1'b1;       #QT;
    m_sda_low = 1'b1; #QT;
    scl = 1'b0;       #QT;
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; #QT;
    scl = 1'b1;       #QT;
    m_sda_low = 1'b0; #QT;
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b; #QT;
    scl = 1'b1;     #HT;
    scl = 1'b0;     #QT;
  endtask

  task automatic recv_bit(output logic b);
    m_sda_low = 1'b0; #QT;
    scl = 1'b1;       #(HT/2);
    b = sda_bus;      #(HT/2);
    scl = 1'b0;       #QT;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(a);
    ack = (a === 1'b0);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic master_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~master_ack);
  endtask

  initial begin
    logic       ack;
    logic       b;
    logic [7:0] d;
    int         p0;

    arstn = 1'b0; scl = 1'b1; m_sda_low = 1'b0;
    m_tready = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00;
    s_src[0] = 8'h00; s_src[1] = 8'h00; s_src[2] = 8'h00; s_src[3] = 8'h00;
    #100;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_busy", busy, 0);
    check("rst_sda", sda_bus, 1);
    arstn = 1'b1;
    #200;

    // Two-byte write, downstream always ready
    set_tready(1'b1);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    i2c_start();
    write_byte(8'hA0, ack); check("t1_addr_ack", ack, 1);
    check("t1_busy", busy, 1);
    write_byte(8'hA5, ack); check("t1_d0_ack", ack, 1);
    write_byte(8'h3C, ack); check("t1_d1_ack", ack, 1);
    i2c_stop();
    #500;
    check("t1_busy_after_stop", busy, 0);
    check("t1_deliveries", deliveries, 2);

    // Wrong address
    dut_drove = 1'b0;
    i2c_start();
    write_byte(8'hA2, ack); check("t2_addr_nack", ack, 0);
    check("t2_busy", busy, 0);
    write_byte(8'h11, ack); check("t2_data_nack", ack, 0);
    i2c_stop();
    #500;
    check("t2_sda_never_driven", dut_drove, 0);
    check("t2_deliveries", deliveries, 2);

    // Read two bytes: master ACK then NACK
    s_src[0] = 8'h5A; s_src[1] = 8'hC3;
    s_idx = 0; s_tdata = 8'h5A; s_tvalid = 1'b1;
    p0 = s_pulses;
    i2c_start();
    write_byte(8'hA1, ack); check("t3_addr_ack", ack, 1);
    read_byte(d, 1'b1); check("t3_rd0", d, 8'h5A);
    read_byte(d, 1'b0); check("t3_rd1", d, 8'hC3);
    i2c_stop();
    #500;
    check("t3_tready_pulses", s_pulses - p0, 2);
    s_tvalid = 1'b0;

    // Downstream stalled: second byte dropped
    set_tready(1'b0);
    exp_q.push_back(8'hA5);
    i2c_start();
    write_byte(8'hA0, ack); check("t4_addr_ack", ack, 1);
    write_byte(8'hA5, ack); check("t4_d0_ack", ack, 1);
    write_byte(8'h3C, ack); check("t4_d1_nack", ack, 0);
    i2c_stop();
    #200;
    check("t4_held_valid", m_tvalid, 1);
    check("t4_held_data", m_tdata, 8'hA5);
    check("t4_deliveries_before", deliveries, 2);
    set_tready(1'b1);
    for (int i = 0; i < 50 && deliveries < 3; i++) @(posedge clk);
    #1;
    check("t4_deliveries_after", deliveries, 3);
    check("t4_valid_cleared", m_tvalid, 0);

    // Read with no source data
    p0 = s_pulses;
    i2c_start();
    write_byte(8'hA1, ack); check("t5_addr_ack", ack, 1);
    read_byte(d, 1'b0); check("t5_rd_ff", d, 8'hFF);
    i2c_stop();
    #500;
    check("t5_tready_pulses", s_pulses - p0, 0);

    // Reset during bit 4 of a data byte, then a fresh write
    i2c_start();
    write_byte(8'hA0, ack); check("t6_addr_ack", ack, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    m_sda_low = 1'b1; #QT;
    arstn = 1'b0;
    m_sda_low = 1'b0;
    #50;
    check("t6_rst_sda", sda_bus, 1);
    check("t6_rst_valid", m_tvalid, 0);
    check("t6_rst_busy", busy, 0);
    arstn = 1'b1;
    #QT;
    m_sda_low = 1'b1;
    scl = 1'b1; #HT;
    scl = 1'b0; #QT;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    recv_bit(b); check("t6_ignored_nack", b, 1);
    exp_q.push_back(8'h77);
    i2c_start();
    write_byte(8'hA0, ack); check("t6_re_addr_ack", ack, 1);
    write_byte(8'h77, ack); check("t6_re_d0_ack", ack, 1);
    i2c_stop();
    #500;
    check("t6_deliveries", deliveries, 4);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
